wb_timer: RTL and testbench
===========================

# wb_timer

Wishbone classic slave holding a free-running 32-bit counter with up to four compare channels and a level interrupt per channel. It sits on the data bus as a responder to the CPU's data-bus master. Its `interrupts` outputs feed the CPU interrupt inputs, through the board-level priority encoder that produces `inter[2:0]`.

## Interface
- `CHANNELS`, default 4: number of compare channels, legal range 1..4.
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `bus`  `if_wb.slave`  —  Wishbone port.
  - Signals used: `cyc`, `stb`, `we`, `sel[3:0]`, `adr[31:0]`, slave data out, master data in, `ack`.
  - Under `NO_MODPORT_EXPRESSIONS`, the data fields are `dat_m` (write data in) and `dat_s` (read data out).
- `interrupts`  out  4  per-channel level interrupt; bits at index `CHANNELS` and above are tied to 0.

## Operation
- Register map, word index `adr[4:2]`. Higher address bits are ignored; full decode happens in the interconnect.
  - 0 CONTROL, read/write:
    - [3:0] channel enable
    - [7:4] interrupt enable
    - [8] RUN
    - other bits read 0
  - 1 STATUS: [3:0] match flags; write-1-to-clear; other bits read 0.
  - 2 COUNT: read/write.
  - 3 PRESCALE: read/write (see Configuration).
  - 4..7 COMPARE0..3: read/write. Indices for channels at or above `CHANNELS` read 0 and ignore writes.
- Writes honour `sel` per byte lane.
  - Unselected bytes keep their value.
  - STATUS clears only flag bits inside selected bytes that are written as 1.
- Reads return the full 32-bit word regardless of `sel`; lane extraction is the master's job.
- Tick: a tick occurs when RUN=1 and the prescaler fires.
- Counting: on a tick, COUNT <= COUNT+1 (mod 2^32), so 0xFFFF_FFFF wraps to 0.
- Matching: on a tick, if the new COUNT equals COMPAREn and channel enable n = 1, STATUS flag n is set.
  - No tick means no match, so a stopped counter sitting on the compare value never re-flags.
- `interrupts[n]` = flag n AND interrupt enable n, decoded combinationally from registers only.
- Simultaneous events:
  - A bus write to COUNT wins over an increment that cycle; no match is evaluated that cycle.
  - Flag set by a match wins over a write-1-to-clear in the same cycle.
  - A COMPARE write takes effect for matches from the following cycle.

## Timing
- Reset values:
  - `ack`, read data, CONTROL, STATUS, COUNT, PRESCALE and the prescaler count are all 0.
  - COMPAREn = 0xFFFF_FFFF.
  - `interrupts` = 0.
- Handshake:
  - At each edge, `ack` <= `cyc & stb & ~ack`.
  - `ack` is high for exactly one cycle per access, one cycle after `stb` is seen.
  - If `stb` is held across transfers, `ack` toggles, giving one access per two cycles.
- Write data is committed on the same edge that raises `ack`.
- Read data is registered on that edge and is valid while `ack` is high. It reflects register state before any same-edge update.
- `cyc` or `stb` dropping before `ack`: the access is abandoned, with no write and no `ack`.
- `rst_i` asserted mid-access: `ack` clears immediately and the pending write is lost.
- Match to flag takes one edge. Flag to `interrupts` is combinational, so the interrupt is visible in the cycle after the tick edge.

## Configuration
- `WB_TIMER_PRESCALE_EN` defined:
  - PRESCALE (P) is a live 32-bit register and the prescaler fires once every P+1 clocks; P=0 means every clock.
  - The prescaler count is internal. It resets to 0 whenever PRESCALE is written or RUN is 0.
- `WB_TIMER_PRESCALE_EN` undefined:
  - The prescaler fires every clock.
  - PRESCALE reads 0 and ignores writes.
  - No prescaler flops are synthesized.

## Structure
- Shared package `timerDef`:
  - `timer_reg_t` enum for the register indices
  - CONTROL bit-position constants
  - COMPARE reset constant
- Sub-module `timer_channel` holds per-channel state; instantiated `CHANNELS` times.
  - Inputs: tick, new count, enables, write strobes.
  - Held state: COMPARE register and match flag.
  - Output: gated interrupt.
- The top level holds the bus FSM, CONTROL, COUNT and the prescaler.

## Test plan
- Reset, then read all 8 indices:
  - each `ack` arrives exactly one cycle after `stb`;
  - COMPARE0..3 = 0xFFFF_FFFF, all others 0, `interrupts` = 0.
- Byte-lane write: write 0xAABBCCDD to COMPARE1 with `sel`=4'b0100 → read back 0xFFBBFFFF.
- Match:
  - Setup: COMPARE0=10, COUNT=0, CONTROL=0x111, PRESCALE=0.
  - Required: flag0 sets on the edge where COUNT becomes 10; `interrupts[0]`=1 the next cycle.
  - Write STATUS=0x1 → `interrupts[0]`=0.
- Wrap: COUNT=0xFFFF_FFFE, COMPARE2=0, channel 2 enabled, RUN=1 → COUNT reaches 0 after 2 ticks and flag2 sets.
- Collisions:
  - COUNT write coinciding with a tick: COUNT holds the written value and no flag is set.
  - Clear coinciding with a match: the flag stays 1.
- `WB_TIMER_PRESCALE_EN` builds:
  - With macro, PRESCALE=3 → COUNT advances every 4 clocks.
  - Without macro, PRESCALE reads 0 after writing 5.

Source files
------------

// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer: register indices, CONTROL layout,
// COMPARE reset value and the byte-lane merge helper.
package timerDef;

    typedef enum logic [2:0] {
        REG_CONTROL  = 3'd0,
        REG_STATUS   = 3'd1,
        REG_COUNT    = 3'd2,
        REG_PRESCALE = 3'd3,
        REG_COMPARE0 = 3'd4,
        REG_COMPARE1 = 3'd5,
        REG_COMPARE2 = 3'd6,
        REG_COMPARE3 = 3'd7
    } timer_reg_t;

    localparam int          CTRL_CHEN_LSB = 0;
    localparam int          CTRL_IEN_LSB  = 4;
    localparam int          CTRL_RUN_BIT  = 8;
    localparam logic [31:0] CTRL_MASK     = 32'h0000_01FF;
    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

    // Replace only the byte lanes selected by sel, keep the rest of old_v.
    function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_timer_if.sv
// Wishbone classic bus bundle; dat_m carries master write data, dat_s slave read data.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        ack;

    modport master (output cyc, stb, we, sel, adr, dat_m, input dat_s, ack);
    modport slave  (input cyc, stb, we, sel, adr, dat_m, output dat_s, ack);
endinterface

// File: rtl/wb_timer_channel.sv
// One compare channel: COMPARE register, sticky match flag and gated interrupt.
module timer_channel
    import timerDef::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tick_i,
    input  logic [31:0] count_nxt_i,
    input  logic        ch_en_i,
    input  logic        irq_en_i,
    input  logic        cmp_we_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  sel_i,
    input  logic        clr_i,
    output logic [31:0] cmp_o,
    output logic        flag_o,
    output logic        irq_o
);

    logic [31:0] cmp_q, cmp_d;
    logic        flag_q, flag_d;
    logic        match;

    // Compare against the registered value so a same-cycle write only counts next cycle.
    assign match  = tick_i && ch_en_i && (count_nxt_i == cmp_q);
    assign cmp_d  = cmp_we_i ? apply_sel(cmp_q, wdata_i, sel_i) : cmp_q;
    assign flag_d = match ? 1'b1 : (clr_i ? 1'b0 : flag_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmp_q  <= COMPARE_RESET;
            flag_q <= 1'b0;
        end else begin
            cmp_q  <= cmp_d;
            flag_q <= flag_d;
        end
    end

    assign cmp_o  = cmp_q;
    assign flag_o = flag_q;
    assign irq_o  = flag_q & irq_en_i;

endmodule

// File: rtl/wb_timer.sv
// Wishbone classic timer: free-running 32-bit COUNT with up to four compare channels.
// Define WB_TIMER_PRESCALE_EN to build the programmable prescaler.
module wb_timer
    import timerDef::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_wb.slave        bus,
    output logic [3:0] interrupts
);

    typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_t;

    bus_state_t  bus_state_q, bus_state_d;
    logic        access;
    logic        wr_en;
    timer_reg_t  reg_idx;
    logic        ctrl_wr, count_wr, status_wr;
    logic [31:0] control_q, control_d;
    logic [31:0] count_q, count_d, count_inc;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] presc_rd;
    logic        presc_fire;
    logic        run, tick, chan_tick;
    logic [31:0] cmp_w [4];
    logic [3:0]  flag_w;
    logic        unused_adr;

    assign unused_adr = ^{bus.adr[31:5], bus.adr[1:0]};

    always_comb begin
        bus_state_d = bus_state_q;
        access      = 1'b0;
        case (bus_state_q)
            BUS_IDLE: begin
                if (bus.cyc && bus.stb) begin
                    access      = 1'b1;
                    bus_state_d = BUS_ACK;
                end
            end
            BUS_ACK:  bus_state_d = BUS_IDLE;
            default:  bus_state_d = BUS_IDLE;
        endcase
    end

    assign wr_en     = access & bus.we;
    assign reg_idx   = timer_reg_t'(bus.adr[4:2]);
    assign ctrl_wr   = wr_en && (reg_idx == REG_CONTROL);
    assign count_wr  = wr_en && (reg_idx == REG_COUNT);
    assign status_wr = wr_en && (reg_idx == REG_STATUS);

    assign run       = control_q[CTRL_RUN_BIT];
    assign tick      = run & presc_fire;
    assign count_inc = count_q + 32'd1;
    // A COUNT write overrides the increment and suppresses matching for that edge.
    assign chan_tick = tick & ~count_wr;

    assign control_d = ctrl_wr ? (apply_sel(control_q, bus.dat_m, bus.sel) & CTRL_MASK)
                               : control_q;
    assign count_d   = count_wr ? apply_sel(count_q, bus.dat_m, bus.sel)
                                : (tick ? count_inc : count_q);

`ifdef WB_TIMER_PRESCALE_EN
    logic        presc_wr;
    logic [31:0] presc_q, presc_d, pcnt_q, pcnt_d;

    assign presc_wr   = wr_en && (reg_idx == REG_PRESCALE);
    assign presc_d    = presc_wr ? apply_sel(presc_q, bus.dat_m, bus.sel) : presc_q;
    assign presc_fire = (pcnt_q == presc_q);
    assign pcnt_d     = (presc_wr || !run || presc_fire) ? 32'd0 : pcnt_q + 32'd1;
    assign presc_rd   = presc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            pcnt_q  <= '0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
`else
    assign presc_fire = 1'b1;
    assign presc_rd   = '0;
`endif

    for (genvar n = 0; n < 4; n++) begin : g_ch
        if (n < CHANNELS) begin : g_on
            logic cmp_we, clr;
            assign cmp_we = wr_en && bus.adr[4] && (bus.adr[3:2] == 2'(n));
            assign clr    = status_wr && bus.sel[0] && bus.dat_m[n];

            timer_channel u_ch (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .tick_i      (chan_tick),
                .count_nxt_i (count_inc),
                .ch_en_i     (control_q[CTRL_CHEN_LSB + n]),
                .irq_en_i    (control_q[CTRL_IEN_LSB + n]),
                .cmp_we_i    (cmp_we),
                .wdata_i     (bus.dat_m),
                .sel_i       (bus.sel),
                .clr_i       (clr),
                .cmp_o       (cmp_w[n]),
                .flag_o      (flag_w[n]),
                .irq_o       (interrupts[n])
            );
        end else begin : g_off
            assign cmp_w[n]      = '0;
            assign flag_w[n]     = 1'b0;
            assign interrupts[n] = 1'b0;
        end
    end

    // Read data captures pre-update register state on the edge that raises ack.
    always_comb begin
        rdata_d = rdata_q;
        if (access) begin
            case (reg_idx)
                REG_CONTROL:  rdata_d = control_q;
                REG_STATUS:   rdata_d = {28'h0, flag_w};
                REG_COUNT:    rdata_d = count_q;
                REG_PRESCALE: rdata_d = presc_rd;
                default:      rdata_d = cmp_w[bus.adr[3:2]];
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus_state_q <= BUS_IDLE;
            rdata_q     <= '0;
            control_q   <= '0;
            count_q     <= '0;
        end else begin
            bus_state_q <= bus_state_d;
            rdata_q     <= rdata_d;
            control_q   <= control_d;
            count_q     <= count_d;
        end
    end

    assign bus.ack   = (bus_state_q == BUS_ACK);
    assign bus.dat_s = rdata_q;

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: register reset values, byte lanes, matching, wrap,
// collisions and the prescaler build option.
module tb_wb_timer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] interrupts;
    int         n_cmp = 0;
    int         n_err = 0;

    if_wb bus();

    wb_timer #(.CHANNELS(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (bus),
        .interrupts (interrupts)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [2:0] I_CTRL = 3'd0, I_STAT = 3'd1, I_CNT = 3'd2, I_PRE = 3'd3,
                           I_CMP0 = 3'd4, I_CMP1 = 3'd5, I_CMP2 = 3'd6;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [2:0] idx, input logic [31:0] wd,
                           input logic [3:0] sel, output logic [31:0] rd);
        int lat;
        @(negedge clk_i);
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = we;
        bus.adr   = {27'h0000123, idx, 2'b00};
        bus.dat_m = wd;
        bus.sel   = sel;
        lat = 0;
        do begin
            @(posedge clk_i);
            #1;
            lat++;
        end while (!bus.ack && lat < 8);
        rd = bus.dat_s;
        check("ack_latency", lat, 1);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] wd, input logic [3:0] sel = 4'hF);
        logic [31:0] dummy;
        wb_xfer(1'b1, idx, wd, sel, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] v;
        wb_xfer(1'b0, idx, 32'h0, 4'hF, v);
        check(tag, v, exp);
    endtask

    task automatic wait_irq(input int bit_n, output int k);
        k = 1;
        while (!interrupts[bit_n] && k < 50) begin
            @(posedge clk_i);
            #1;
            k++;
        end
    endtask

    initial begin
        int k;
        rst_i     = 1'b1;
        bus.cyc   = 1'b0;
        bus.stb   = 1'b0;
        bus.we    = 1'b0;
        bus.sel   = 4'h0;
        bus.adr   = '0;
        bus.dat_m = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ack", {31'h0, bus.ack}, 32'h0);
        check("rst_irq", {28'h0, interrupts}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rd_chk($sformatf("rst_reg%0d", i), 3'(i), (i >= 4) ? 32'hFFFF_FFFF : 32'h0);
        end

        wr(I_CMP1, 32'hAABB_CCDD, 4'b0100);
        rd_chk("byte_lane_cmp1", I_CMP1, 32'hFFBB_FFFF);

        // Match on channel 0: ten ticks after RUN is committed.
        wr(I_CTRL, 32'h0);
        wr(I_PRE, 32'h0);
        wr(I_CMP0, 32'd10);
        wr(I_CNT, 32'h0);
        wr(I_CTRL, 32'h111);
        wait_irq(0, k);
        check("match_edges", k, 10);
        check("match_irq", {28'h0, interrupts}, 32'h1);
        wr(I_CTRL, 32'h011);
        rd_chk("match_status", I_STAT, 32'h1);
        wr(I_STAT, 32'h1);
        check("clear_irq", {28'h0, interrupts}, 32'h0);
        rd_chk("clear_status", I_STAT, 32'h0);

        // Wrap through zero on channel 2.
        wr(I_CMP2, 32'h0);
        wr(I_CNT, 32'hFFFF_FFFE);
        wr(I_CTRL, 32'h144);
        wait_irq(2, k);
        check("wrap_edges", k, 2);
        check("wrap_irq", {28'h0, interrupts}, 32'h4);
        wr(I_CTRL, 32'h044);
        rd_chk("wrap_count", I_CNT, 32'h1);
        rd_chk("wrap_status", I_STAT, 32'h4);
        wr(I_STAT, 32'h4);

        // COUNT write collides with a tick: written value wins, no match.
        wr(I_CMP0, 32'h500);
        wr(I_CNT, 32'h0);
        wr(I_CTRL, 32'h101);
        wr(I_CNT, 32'h500);
        wr(I_CTRL, 32'h001);
        rd_chk("coll_count", I_CNT, 32'h502);
        rd_chk("coll_status", I_STAT, 32'h0);

        // STATUS clear collides with a match: flag survives.
        wr(I_CMP0, 32'd2);
        wr(I_CNT, 32'h0);
        wr(I_CTRL, 32'h111);
        wr(I_STAT, 32'h1);
        wr(I_CTRL, 32'h011);
        rd_chk("clrmatch_status", I_STAT, 32'h1);
        check("clrmatch_irq", {28'h0, interrupts}, 32'h1);
        wr(I_STAT, 32'h1);
        rd_chk("clrmatch_cleared", I_STAT, 32'h0);

        // Stopped counter resting on the compare value never re-flags.
        wr(I_CNT, 32'd4);
        wr(I_CMP0, 32'd4);
        repeat (4) @(posedge clk_i);
        rd_chk("stopped_status", I_STAT, 32'h0);
        rd_chk("ctrl_readback", I_CTRL, 32'h011);

`ifdef WB_TIMER_PRESCALE_EN
        wr(I_CTRL, 32'h0);
        wr(I_CNT, 32'h0);
        wr(I_PRE, 32'd3);
        rd_chk("presc_read", I_PRE, 32'd3);
        wr(I_CTRL, 32'h100);
        repeat (10) @(posedge clk_i);
        wr(I_CTRL, 32'h0);
        rd_chk("presc_count", I_CNT, 32'd3);
`else
        wr(I_PRE, 32'd5);
        rd_chk("presc_read", I_PRE, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
